// File: rtl/frame_receiver_if.sv
// MAC client RX byte stream: data byte, byte strobe and the one-cycle frame status strobes.
// The MAC side drives everything; the frame receiver only observes.
interface frame_receiver_if;
  logic [7:0] mac_rx_data;
  logic       mac_rx_dvld;
  logic       mac_rx_good_frame;
  logic       mac_rx_bad_frame;

  modport master (
    output mac_rx_data,
    output mac_rx_dvld,
    output mac_rx_good_frame,
    output mac_rx_bad_frame
  );

  modport slave (
    input mac_rx_data,
    input mac_rx_dvld,
    input mac_rx_good_frame,
    input mac_rx_bad_frame
  );
endinterface

// File: rtl/frame_receiver.sv
// Receive-side frame parser: captures Ethernet header fields, length and first-byte time,
// filters on destination MAC, emits a one-cycle summary per good frame and keeps good/bad counters.
module frame_receiver #(
  parameter logic [47:0] MY_MAC_ADDR = 48'h004e46324300,
  parameter int          MAX_LEN     = 1518,
  parameter int          STATUS_TMO  = 16
) (
  input  logic                 rx_clk,
  input  logic                 reset_n,
  frame_receiver_if.slave      rx,
  input  logic [31:0]          time_now,
  output logic                 conf_rx_en,
  output logic                 conf_rx_jumbo_en,
  output logic                 frame_valid,
  output logic                 frame_dst_match,
  output logic [47:0]          frame_src_addr,
  output logic [15:0]          frame_eth_type,
  output logic [15:0]          frame_len,
  output logic [31:0]          frame_sof_time,
  output logic [15:0]          good_cnt,
  output logic [15:0]          bad_cnt
);

  localparam int JUMBO_LEN = 9018;
  localparam int TMO_W     = $clog2(STATUS_TMO) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_DST, S_SRC, S_TYPE, S_PAYLOAD, S_STATUS, S_DROP
  } state_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Header section that will receive the byte at position idx.
  function automatic state_t hdr_state(input logic [15:0] idx);
    if (idx < 16'd6)       return S_DST;
    else if (idx < 16'd12) return S_SRC;
    else if (idx < 16'd14) return S_TYPE;
    else                   return S_PAYLOAD;
  endfunction

  state_t             state_q;
  logic               dvld_q;
  logic [15:0]        len_q;
  logic [TMO_W-1:0]   tmo_q;
  logic [47:0]        dst_q;
  logic [47:0]        src_q;
  logic [15:0]        type_q;
  logic [31:0]        sof_q;

  logic               conf_rx_en_q;
  logic               frame_valid_q;
  logic               frame_dst_match_q;
  logic [47:0]        frame_src_addr_q;
  logic [15:0]        frame_eth_type_q;
  logic [15:0]        frame_len_q;
  logic [31:0]        frame_sof_time_q;
  logic [15:0]        good_cnt_q;
  logic [15:0]        bad_cnt_q;

  logic [15:0]        len_limit_d;
  logic [15:0]        len_inc_d;
  logic               frame_ok_d;
  logic               status_end_d;

  assign conf_rx_jumbo_en = 1'b0;

  always_comb begin
    len_limit_d  = conf_rx_jumbo_en ? 16'(JUMBO_LEN) : 16'(MAX_LEN);
    len_inc_d    = sat_inc(len_q);
    frame_ok_d   = rx.mac_rx_good_frame && !rx.mac_rx_bad_frame &&
                   (len_q >= 16'd14) && (len_q <= len_limit_d);
    // Any of these closes out the frame waiting in STATUS.
    status_end_d = rx.mac_rx_good_frame || rx.mac_rx_bad_frame || rx.mac_rx_dvld ||
                   (tmo_q == TMO_W'(STATUS_TMO - 1));
  end

  always_ff @(posedge rx_clk) begin
    dvld_q        <= rx.mac_rx_dvld;
    frame_valid_q <= 1'b0;
    if (!reset_n) begin
      state_q           <= S_IDLE;
      len_q             <= '0;
      tmo_q             <= '0;
      conf_rx_en_q      <= 1'b0;
      frame_dst_match_q <= 1'b0;
      frame_src_addr_q  <= '0;
      frame_eth_type_q  <= '0;
      frame_len_q       <= '0;
      frame_sof_time_q  <= '0;
      good_cnt_q        <= '0;
      bad_cnt_q         <= '0;
    end else begin
      conf_rx_en_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          // Strobe already high on the previous cycle means we woke up mid-frame.
          if (rx.mac_rx_dvld && dvld_q) begin
            state_q <= S_DROP;
          end else if (rx.mac_rx_dvld) begin
            dst_q   <= {dst_q[39:0], rx.mac_rx_data};
            sof_q   <= time_now;
            len_q   <= 16'd1;
            state_q <= S_DST;
          end
        end
        S_DST, S_SRC, S_TYPE, S_PAYLOAD: begin
          if (rx.mac_rx_dvld) begin
            if (len_q < 16'd6)       dst_q  <= {dst_q[39:0], rx.mac_rx_data};
            else if (len_q < 16'd12) src_q  <= {src_q[39:0], rx.mac_rx_data};
            else if (len_q < 16'd14) type_q <= {type_q[7:0], rx.mac_rx_data};
            len_q   <= len_inc_d;
            state_q <= hdr_state(len_inc_d);
          end else begin
            tmo_q   <= '0;
            state_q <= S_STATUS;
          end
        end
        S_STATUS: begin
          if (frame_ok_d) begin
            frame_valid_q     <= 1'b1;
            frame_dst_match_q <= (dst_q == MY_MAC_ADDR) || (dst_q == 48'hFFFF_FFFF_FFFF);
            frame_src_addr_q  <= src_q;
            frame_eth_type_q  <= type_q;
            frame_len_q       <= len_q;
            frame_sof_time_q  <= sof_q;
            good_cnt_q        <= good_cnt_q + 16'd1;
          end else if (status_end_d) begin
            bad_cnt_q <= bad_cnt_q + 16'd1;
          end
          // A new frame arriving before status closes the old one and starts at byte 0.
          if (rx.mac_rx_dvld) begin
            dst_q   <= {dst_q[39:0], rx.mac_rx_data};
            sof_q   <= time_now;
            len_q   <= 16'd1;
            state_q <= S_DST;
          end else if (status_end_d) begin
            state_q <= S_IDLE;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end
        S_DROP: begin
          if (!rx.mac_rx_dvld) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign conf_rx_en      = conf_rx_en_q;
  assign frame_valid     = frame_valid_q;
  assign frame_dst_match = frame_dst_match_q;
  assign frame_src_addr  = frame_src_addr_q;
  assign frame_eth_type  = frame_eth_type_q;
  assign frame_len       = frame_len_q;
  assign frame_sof_time  = frame_sof_time_q;
  assign good_cnt        = good_cnt_q;
  assign bad_cnt         = bad_cnt_q;

endmodule

// File: tb/tb_frame_receiver.sv
// Scoreboard bench for frame_receiver: expected summaries are queued when a good status is
// driven and compared when frame_valid appears; counters are checked after each frame.
module tb_frame_receiver;

  localparam logic [47:0] MY_MAC = 48'h004e46324300;
  localparam logic [47:0] BCAST  = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] SRC_A  = 48'h0012E228130E;
  localparam logic [47:0] SRC_B  = 48'h0A0B0C0D0E0F;

  logic        rx_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] time_now = 32'h1000_0000;

  logic        conf_rx_en, conf_rx_jumbo_en, frame_valid, frame_dst_match;
  logic [47:0] frame_src_addr;
  logic [15:0] frame_eth_type, frame_len, good_cnt, bad_cnt;
  logic [31:0] frame_sof_time;

  frame_receiver_if rx_if ();

  frame_receiver dut (
    .rx_clk           (rx_clk),
    .reset_n          (reset_n),
    .rx               (rx_if.slave),
    .time_now         (time_now),
    .conf_rx_en       (conf_rx_en),
    .conf_rx_jumbo_en (conf_rx_jumbo_en),
    .frame_valid      (frame_valid),
    .frame_dst_match  (frame_dst_match),
    .frame_src_addr   (frame_src_addr),
    .frame_eth_type   (frame_eth_type),
    .frame_len        (frame_len),
    .frame_sof_time   (frame_sof_time),
    .good_cnt         (good_cnt),
    .bad_cnt          (bad_cnt)
  );

  always #5 rx_clk = ~rx_clk;

  typedef struct {
    logic        dm;
    logic [47:0] src;
    logic [15:0] typ;
    logic [15:0] len;
    logic [31:0] sof;
    int          due;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_chk = 0;
  int          n_err = 0;
  int          pc = 0;
  logic [15:0] exp_good = 16'd0;
  logic [15:0] exp_bad  = 16'd0;

  always @(posedge rx_clk) pc <= pc + 1;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Scoreboard consumer.
  always @(negedge rx_clk) begin
    if (reset_n && frame_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", 64'd1, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("valid_cycle", 64'(pc), 64'(mon_e.due));
        chk("dst_match", 64'(frame_dst_match), 64'(mon_e.dm));
        chk("src_addr", 64'(frame_src_addr), 64'(mon_e.src));
        chk("eth_type", 64'(frame_eth_type), 64'(mon_e.typ));
        chk("frame_len", 64'(frame_len), 64'(mon_e.len));
        chk("sof_time", 64'(frame_sof_time), 64'(mon_e.sof));
      end
    end
  end

  function automatic logic [7:0] byte_at(input logic [47:0] d, input logic [47:0] s,
                                         input logic [15:0] t, input int i);
    if (i < 6)       return d[47-8*i -: 8];
    else if (i < 12) return s[47-8*(i-6) -: 8];
    else if (i < 14) return t[15-8*(i-12) -: 8];
    else             return 8'(i) ^ 8'h5A;
  endfunction

  task automatic tick();
    @(negedge rx_clk);
    time_now = time_now + 32'd7;
  endtask

  // st: 0 = no status, 1 = good, 2 = bad, 3 = good and bad together.
  task automatic send(input logic [47:0] dst, input logic [47:0] src, input logic [15:0] typ,
                      input int n, input int st, input bit exp_valid, input bit exp_dm);
    logic [31:0] sof;
    exp_t        e;
    sof = '0;
    for (int i = 0; i < n; i++) begin
      tick();
      rx_if.mac_rx_dvld = 1'b1;
      rx_if.mac_rx_data = byte_at(dst, src, typ, i);
      if (i == 0) sof = time_now;
    end
    tick();
    rx_if.mac_rx_dvld = 1'b0;
    rx_if.mac_rx_data = 8'h00;
    if (st != 0) begin
      tick();
      rx_if.mac_rx_good_frame = (st == 1) || (st == 3);
      rx_if.mac_rx_bad_frame  = (st == 2) || (st == 3);
      if (exp_valid) begin
        e.dm  = exp_dm;
        e.src = src;
        e.typ = typ;
        e.len = 16'(n);
        e.sof = sof;
        e.due = pc + 1;
        sb.push_back(e);
      end
      tick();
      rx_if.mac_rx_good_frame = 1'b0;
      rx_if.mac_rx_bad_frame  = 1'b0;
    end
  endtask

  task automatic cnt_chk(input string tag);
    tick();
    tick();
    chk({tag, "_good_cnt"}, 64'(good_cnt), 64'(exp_good));
    chk({tag, "_bad_cnt"}, 64'(bad_cnt), 64'(exp_bad));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rx_if.mac_rx_data       = 8'h00;
    rx_if.mac_rx_dvld       = 1'b0;
    rx_if.mac_rx_good_frame = 1'b0;
    rx_if.mac_rx_bad_frame  = 1'b0;
    repeat (3) tick();
    chk("rst_conf_rx_en", 64'(conf_rx_en), 64'd0);
    chk("rst_jumbo_en", 64'(conf_rx_jumbo_en), 64'd0);
    chk("rst_frame_valid", 64'(frame_valid), 64'd0);
    chk("rst_good_cnt", 64'(good_cnt), 64'd0);
    chk("rst_bad_cnt", 64'(bad_cnt), 64'd0);
    reset_n = 1'b1;
    tick();
    chk("conf_rx_en_after_release", 64'(conf_rx_en), 64'd1);

    // Broadcast ARP, foreign unicast, own address at minimum header length.
    send(BCAST, SRC_A, 16'h0806, 60, 1, 1'b1, 1'b1);
    exp_good = exp_good + 16'd1;
    cnt_chk("arp");
    send(48'h004e46324301, SRC_B, 16'h0800, 64, 1, 1'b1, 1'b0);
    exp_good = exp_good + 16'd1;
    cnt_chk("foreign");
    send(MY_MAC, SRC_B, 16'h86DD, 14, 1, 1'b1, 1'b1);
    exp_good = exp_good + 16'd1;
    cnt_chk("len14");

    // Runt and oversize frames with good status.
    send(MY_MAC, SRC_A, 16'h0800, 10, 1, 1'b0, 1'b0);
    exp_bad = exp_bad + 16'd1;
    cnt_chk("runt");
    send(MY_MAC, SRC_A, 16'h0800, 1600, 1, 1'b0, 1'b0);
    exp_bad = exp_bad + 16'd1;
    cnt_chk("oversize");
    send(MY_MAC, SRC_A, 16'h88B5, 1518, 1, 1'b1, 1'b1);
    exp_good = exp_good + 16'd1;
    cnt_chk("len1518");
    send(MY_MAC, SRC_A, 16'h88B5, 1519, 1, 1'b0, 1'b0);
    exp_bad = exp_bad + 16'd1;
    cnt_chk("len1519");

    // Bad status, both strobes, timeout, then a normal frame.
    send(MY_MAC, SRC_B, 16'h0800, 60, 2, 1'b0, 1'b0);
    exp_bad = exp_bad + 16'd1;
    cnt_chk("bad_status");
    send(MY_MAC, SRC_B, 16'h0800, 60, 3, 1'b0, 1'b0);
    exp_bad = exp_bad + 16'd1;
    cnt_chk("both_status");
    send(MY_MAC, SRC_B, 16'h0800, 60, 0, 1'b0, 1'b0);
    repeat (20) tick();
    exp_bad = exp_bad + 16'd1;
    cnt_chk("timeout");
    send(BCAST, SRC_B, 16'h0801, 61, 1, 1'b1, 1'b1);
    exp_good = exp_good + 16'd1;
    cnt_chk("after_timeout");

    // New frame starts while the previous one still waits for status.
    send(MY_MAC, SRC_A, 16'h0800, 60, 0, 1'b0, 1'b0);
    send(MY_MAC, SRC_B, 16'h0842, 62, 1, 1'b1, 1'b1);
    exp_bad  = exp_bad + 16'd1;
    exp_good = exp_good + 16'd1;
    cnt_chk("overlap");

    // Reset in the middle of a frame, released while the strobe is still high.
    for (int i = 0; i < 20; i++) begin
      tick();
      rx_if.mac_rx_dvld = 1'b1;
      rx_if.mac_rx_data = byte_at(MY_MAC, SRC_A, 16'h0800, i);
    end
    tick();
    reset_n = 1'b0;
    rx_if.mac_rx_data = 8'h20;
    tick();
    tick();
    chk("midrst_conf_rx_en", 64'(conf_rx_en), 64'd0);
    chk("midrst_good_cnt", 64'(good_cnt), 64'd0);
    chk("midrst_bad_cnt", 64'(bad_cnt), 64'd0);
    chk("midrst_frame_len", 64'(frame_len), 64'd0);
    chk("midrst_src_addr", 64'(frame_src_addr), 64'd0);
    chk("midrst_eth_type", 64'(frame_eth_type), 64'd0);
    chk("midrst_sof_time", 64'(frame_sof_time), 64'd0);
    chk("midrst_dst_match", 64'(frame_dst_match), 64'd0);
    exp_good = 16'd0;
    exp_bad  = 16'd0;
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      rx_if.mac_rx_data = 8'(i + 30);
    end
    tick();
    rx_if.mac_rx_dvld = 1'b0;
    tick();
    rx_if.mac_rx_good_frame = 1'b1;
    tick();
    rx_if.mac_rx_good_frame = 1'b0;
    cnt_chk("dropped");
    send(MY_MAC, SRC_A, 16'h0806, 60, 1, 1'b1, 1'b1);
    exp_good = exp_good + 16'd1;
    cnt_chk("after_drop");

    // Good counter wrap.
    tick();
    force dut.good_cnt_q = 16'hFFFF;
    tick();
    release dut.good_cnt_q;
    tick();
    chk("preload", 64'(good_cnt), 64'hFFFF);
    send(BCAST, SRC_B, 16'h0806, 60, 1, 1'b1, 1'b1);
    exp_good = 16'h0000;
    cnt_chk("wrap");

    repeat (3) tick();
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
